// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V control FSM:
// state encoding, opcodes, datapath select encodings and the decode bundle.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_e;

  // Supported RV32I major opcodes (FENCE and SYSTEM are deliberately absent).
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_DMEM = 2'd0;
  localparam logic [1:0] WB_ALU  = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  localparam logic PC_PLUS4 = 1'b0;
  localparam logic PC_ALU   = 1'b1;
  localparam logic A_RS1    = 1'b0;
  localparam logic A_PC     = 1'b1;
  localparam logic B_RS2    = 1'b0;
  localparam logic B_IMM    = 1'b1;

  // Decoded view of the current instruction, before state gating.
  typedef struct packed {
    logic       asel;
    logic       bsel;
    logic [2:0] imm_sel;
    logic [3:0] alu_sel;
    logic       brun;
    logic [1:0] wbsel;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
    logic       taken;
    logic       illegal;
  } dec_t;

  // funct3 -> ALU op; alt selects SUB (funct3=000) or SRA (funct3=101).
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3,
                                                 input logic       alt);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_ctrl_decode.sv
// Purely combinational instruction decode: maps opcode/funct fields and the
// branch comparator flags to datapath selects and instruction-class flags.
module riscv_ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       br_eq,
  input  logic       br_lt,
  output dec_t       dec
);

  logic cond;

  // Branch condition selected by funct3; undefined encodings never take.
  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = br_eq;
      3'b001:  cond = ~br_eq;
      3'b100:  cond = br_lt;
      3'b101:  cond = ~br_lt;
      3'b110:  cond = br_lt;
      3'b111:  cond = ~br_lt;
      default: cond = 1'b0;
    endcase
  end

  // Opcode decode into select fields and class flags.
  always_comb begin
    // NOTE: every field gets a default before the case so no path can infer a latch.
    dec         = '0;
    dec.asel    = A_RS1;
    dec.bsel    = B_RS2;
    dec.imm_sel = IMM_I;
    dec.alu_sel = ALU_ADD;
    dec.wbsel   = WB_ALU;
    case (opcode)
      OP_R: begin
        dec.alu_sel = alu_from_funct3(funct3, funct7_5);
      end
      OP_IMM: begin
        dec.bsel    = B_IMM;
        // Only SRAI uses inst[30]; for ADDI it is immediate bits, not SUB.
        dec.alu_sel = alu_from_funct3(funct3, funct7_5 && (funct3 == 3'b101));
      end
      OP_LOAD: begin
        dec.bsel    = B_IMM;
        dec.wbsel   = WB_DMEM;
        dec.is_load = 1'b1;
      end
      OP_STORE: begin
        dec.bsel     = B_IMM;
        dec.imm_sel  = IMM_S;
        dec.is_store = 1'b1;
      end
      OP_BRANCH: begin
        dec.asel      = A_PC;
        dec.bsel      = B_IMM;
        dec.imm_sel   = IMM_B;
        dec.brun      = funct3[1];
        dec.is_branch = 1'b1;
        dec.taken     = cond;
      end
      OP_JAL: begin
        dec.asel    = A_PC;
        dec.bsel    = B_IMM;
        dec.imm_sel = IMM_J;
        dec.wbsel   = WB_PC4;
        dec.is_jump = 1'b1;
      end
      OP_JALR: begin
        dec.bsel    = B_IMM;
        dec.wbsel   = WB_PC4;
        dec.is_jump = 1'b1;
      end
      OP_LUI: begin
        dec.bsel    = B_IMM;
        dec.imm_sel = IMM_U;
        dec.alu_sel = ALU_PASSB;
      end
      OP_AUIPC: begin
        dec.asel    = A_PC;
        dec.bsel    = B_IMM;
        dec.imm_sel = IMM_U;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle control FSM: sequences one instruction through
// FETCH/DECODE/EXEC/MEM/WB and gates decoded selects by state.
module riscv_multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] inst,
  input  logic                  br_eq,
  input  logic                  br_lt,
  input  logic                  imem_ready,
  input  logic                  dmem_ready,
  output logic                  imem_req,
  output logic                  inst_we,
  output logic                  dmem_req,
  output logic                  mem_rw,
  output logic                  pc_we,
  output logic                  pc_sel,
  output logic                  asel,
  output logic                  bsel,
  output logic [2:0]            imm_sel,
  output logic [3:0]            alu_sel,
  output logic                  brun,
  output logic                  regwen,
  output logic [1:0]            wbsel,
  output logic                  trap
);

  state_e state_q, state_d;
  dec_t   dec;
  logic   drive_ops;

  // Instruction bits the controller never looks at (register indices, imm).
  logic unused_inst;
  assign unused_inst = ^{inst[DATA_WIDTH-1:31], inst[29:15], inst[11:7]};

  riscv_ctrl_decode u_decode (
    .opcode   (inst[6:0]),
    .funct3   (inst[14:12]),
    .funct7_5 (inst[30]),
    .br_eq    (br_eq),
    .br_lt    (br_lt),
    .dec      (dec)
  );

  // State register; reset forces BOOT immediately.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state flops use non-blocking assignment so all flops update together.
    if (rst) state_q <= ST_BOOT;
    else     state_q <= state_d;
  end

  // Operand selects stay valid from EXEC through WB so the ALU result is stable.
  assign drive_ops = (state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB);

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    inst_we  = 1'b0;
    dmem_req = 1'b0;
    mem_rw   = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_PLUS4;
    asel     = A_RS1;
    bsel     = B_RS2;
    imm_sel  = IMM_I;
    alu_sel  = ALU_ADD;
    brun     = 1'b0;
    regwen   = 1'b0;
    wbsel    = WB_DMEM;
    trap     = 1'b0;

    if (drive_ops) begin
      asel    = dec.asel;
      bsel    = dec.bsel;
      imm_sel = dec.imm_sel;
      alu_sel = dec.alu_sel;
      brun    = dec.brun;
      wbsel   = dec.wbsel;
    end

    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          inst_we = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = dec.illegal ? ST_TRAP : ST_EXEC;
      ST_EXEC:   state_d = (dec.is_load || dec.is_store) ? ST_MEM : ST_WB;
      ST_MEM: begin
        dmem_req = 1'b1;
        mem_rw   = dec.is_store;
        if (dmem_ready) begin
          if (dec.is_store) begin
            // A store retires here; it has no writeback cycle.
            pc_we   = 1'b1;
            pc_sel  = PC_PLUS4;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        pc_we   = 1'b1;
        regwen  = ~dec.is_branch;
        pc_sel  = (dec.is_jump || (dec.is_branch && dec.taken)) ? PC_ALU : PC_PLUS4;
        state_d = ST_FETCH;
      end
      ST_TRAP: trap = 1'b1;
      default: state_d = ST_BOOT;
    endcase
  end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Self-checking bench for riscv_multicycle_ctrl: directed and random
// instructions compared cycle by cycle against a phase-level reference model.
module tb_riscv_multicycle_ctrl;

  typedef enum {P_BOOT, P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB, P_TRAP} phase_e;

  typedef struct packed {
    logic       imem_req;
    logic       inst_we;
    logic       dmem_req;
    logic       mem_rw;
    logic       pc_we;
    logic       pc_sel;
    logic       asel;
    logic       bsel;
    logic [2:0] imm_sel;
    logic [3:0] alu_sel;
    logic       brun;
    logic       regwen;
    logic [1:0] wbsel;
    logic       trap;
  } outs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        br_eq, br_lt, imem_ready, dmem_ready;
  logic        imem_req, inst_we, dmem_req, mem_rw, pc_we, pc_sel, asel, bsel;
  logic [2:0]  imm_sel;
  logic [3:0]  alu_sel;
  logic        brun, regwen, trap;
  logic [1:0]  wbsel;
  outs_t       obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_multicycle_ctrl #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst       (inst),
    .br_eq      (br_eq),
    .br_lt      (br_lt),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .inst_we    (inst_we),
    .dmem_req   (dmem_req),
    .mem_rw     (mem_rw),
    .pc_we      (pc_we),
    .pc_sel     (pc_sel),
    .asel       (asel),
    .bsel       (bsel),
    .imm_sel    (imm_sel),
    .alu_sel    (alu_sel),
    .brun       (brun),
    .regwen     (regwen),
    .wbsel      (wbsel),
    .trap       (trap)
  );

  assign obs = {imem_req, inst_we, dmem_req, mem_rw, pc_we, pc_sel, asel, bsel,
                imm_sel, alu_sel, brun, regwen, wbsel, trap};

  // ---------------- reference model ----------------
  function automatic bit is_legal(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
  endfunction

  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0: return alt ? 4'd1 : 4'd0;
      3'd1: return 4'd2;
      3'd2: return 4'd3;
      3'd3: return 4'd4;
      3'd4: return 4'd5;
      3'd5: return alt ? 4'd7 : 4'd6;
      3'd6: return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  function automatic bit ref_taken(input logic [2:0] f3, input logic eq, input logic lt);
    case (f3)
      3'd0: return eq;       // BEQ
      3'd1: return !eq;      // BNE
      3'd4: return lt;       // BLT
      3'd5: return !lt;      // BGE
      3'd6: return lt;       // BLTU
      3'd7: return !lt;      // BGEU
      default: return 1'b0;
    endcase
  endfunction

  function automatic outs_t model(input phase_e ph, input logic [31:0] ins,
                                  input logic eq, input logic lt, input logic rdy);
    outs_t o;
    logic [6:0] op;
    logic [2:0] f3;
    bit ld, st, br, jal, jalr;
    o    = '0;
    op   = ins[6:0];
    f3   = ins[14:12];
    ld   = (op == 7'b0000011);
    st   = (op == 7'b0100011);
    br   = (op == 7'b1100011);
    jal  = (op == 7'b1101111);
    jalr = (op == 7'b1100111);
    if (ph inside {P_EXEC, P_MEM, P_WB}) begin
      o.wbsel = 2'd1;
      case (op)
        7'b0110011: o.alu_sel = ref_alu(f3, ins[30]);
        7'b0010011: begin o.bsel = 1; o.alu_sel = ref_alu(f3, (f3 == 3'd5) && ins[30]); end
        7'b0000011: begin o.bsel = 1; o.wbsel = 2'd0; end
        7'b0100011: begin o.bsel = 1; o.imm_sel = 3'd1; end
        7'b1100011: begin o.asel = 1; o.bsel = 1; o.imm_sel = 3'd2; o.brun = ins[13]; end
        7'b1101111: begin o.asel = 1; o.bsel = 1; o.imm_sel = 3'd4; o.wbsel = 2'd2; end
        7'b1100111: begin o.bsel = 1; o.wbsel = 2'd2; end
        7'b0110111: begin o.bsel = 1; o.imm_sel = 3'd3; o.alu_sel = 4'd10; end
        default:    begin o.asel = 1; o.bsel = 1; o.imm_sel = 3'd3; end // AUIPC
      endcase
    end
    case (ph)
      P_FETCH: begin o.imem_req = 1; o.inst_we = rdy; end
      P_MEM: begin
        o.dmem_req = 1;
        o.mem_rw   = st;
        if (st && rdy) o.pc_we = 1;
      end
      P_WB: begin
        o.pc_we  = 1;
        o.regwen = !br;
        o.pc_sel = jal || jalr || (br && ref_taken(f3, eq, lt));
      end
      P_TRAP: o.trap = 1;
      default: ;
    endcase
    return o;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input outs_t exp, input bit wb_care);
    outs_t o;
    o = obs;
    // Stores and branches write no register, so their wbsel is a don't-care.
    if (!wb_care) o.wbsel = exp.wbsel;
    checks++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, exp);
    end
  endtask

  task automatic rand_inputs();
    inst       = $urandom;
    br_eq      = 1'($urandom);
    br_lt      = 1'($urandom);
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
  endtask

  // Assert rst on the next falling edge (aborting anything in flight), hold,
  // then release and check the BOOT cycle.
  task automatic do_reset(input string tag, input int cycles);
    @(negedge clk);
    rand_inputs();
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    rst = 1'b1;
    #1 check({tag, " rst-edge"}, '0, 1'b1);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rand_inputs();
      #1 check($sformatf("%s rst%0d", tag, i), '0, 1'b1);
    end
    @(negedge clk);
    rand_inputs();
    rst = 1'b0;
    #1 check({tag, " boot"}, '0, 1'b1);
  endtask

  // Run one legal instruction; abort_at >= 0 stops before that cycle.
  task automatic run_instr(input string tag, input logic [31:0] ins, input int fw,
                           input int mw, input logic eq, input logic lt,
                           input int abort_at);
    phase_e q[$];
    bit ld, st, care;
    int fc, mc;
    logic rdy;
    ld = (ins[6:0] == 7'b0000011);
    st = (ins[6:0] == 7'b0100011);
    for (int i = 0; i <= fw; i++) q.push_back(P_FETCH);
    q.push_back(P_DECODE);
    q.push_back(P_EXEC);
    if (ld || st) for (int i = 0; i <= mw; i++) q.push_back(P_MEM);
    if (!st) q.push_back(P_WB);
    fc = 0;
    mc = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (i == abort_at) break;
      @(negedge clk);
      rand_inputs();
      if (q[i] == P_FETCH) begin
        imem_ready = (fc == fw);
        fc++;
      end else begin
        inst  = ins;
        br_eq = eq;
        br_lt = lt;
      end
      if (q[i] == P_MEM) begin
        dmem_ready = (mc == mw);
        mc++;
      end
      rdy  = (q[i] == P_FETCH) ? imem_ready : dmem_ready;
      care = !(q[i] inside {P_EXEC, P_MEM, P_WB}) ||
             !(st || ins[6:0] == 7'b1100011);
      #1 check($sformatf("%s c%0d %s", tag, i, q[i].name()), model(q[i], ins, eq, lt, rdy), care);
    end
  endtask

  // Fetch an illegal word and verify TRAP is entered and held.
  task automatic run_illegal(input string tag, input logic [31:0] ins, input int hold);
    @(negedge clk);
    rand_inputs();
    imem_ready = 1'b1;
    #1 check({tag, " fetch"}, model(P_FETCH, ins, 0, 0, 1'b1), 1'b1);
    @(negedge clk);
    rand_inputs();
    inst = ins;
    #1 check({tag, " decode"}, '0, 1'b1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      rand_inputs();
      inst = ins;
      #1 check($sformatf("%s trap%0d", tag, i), model(P_TRAP, ins, 0, 0, 0), 1'b1);
    end
    do_reset({tag, " exit"}, 1);
  endtask

  function automatic logic [31:0] rand_legal();
    logic [31:0] w;
    logic [2:0]  f3;
    w = $urandom;
    case ($urandom_range(0, 8))
      0: w[6:0] = 7'b0110011;
      1: w[6:0] = 7'b0010011;
      2: w[6:0] = 7'b0000011;
      3: w[6:0] = 7'b0100011;
      4: begin
        w[6:0] = 7'b1100011;
        f3 = 3'($urandom_range(0, 5));
        if (f3 >= 3'd2) f3 = f3 + 3'd2;   // skip undefined 010/011
        w[14:12] = f3;
      end
      5: w[6:0] = 7'b1101111;
      6: w[6:0] = 7'b1100111;
      7: w[6:0] = 7'b0110111;
      default: w[6:0] = 7'b0010111;
    endcase
    return w;
  endfunction

  initial begin
    logic [31:0] w;
    rst = 1'b1;
    rand_inputs();

    // Reset held 3 cycles, BOOT, then first fetch one cycle after release.
    do_reset("reset", 3);

    run_instr("ADD",       32'h002081B3, 0, 0, 1'b0, 1'b0, -1);
    run_instr("LW",        32'h0080A283, 0, 2, 1'b0, 1'b0, -1);
    run_instr("BNE ne",    32'h00209463, 0, 0, 1'b0, 1'b0, -1);
    run_instr("BNE eq",    32'h00209463, 0, 0, 1'b1, 1'b0, -1);
    run_instr("BLTU",      32'h0020E463, 0, 0, 1'b0, 1'b1, -1);
    run_instr("JALR",      32'h000080E7, 0, 0, 1'b0, 1'b0, -1);
    run_instr("SW",        32'h0020A423, 1, 1, 1'b0, 1'b0, -1);
    run_instr("SRAI",      32'h4030D093, 0, 0, 1'b0, 1'b0, -1);
    run_instr("ADDI b30",  32'h40008093, 0, 0, 1'b0, 1'b0, -1);
    run_instr("SUB",       32'h402081B3, 2, 0, 1'b0, 1'b0, -1);
    run_instr("LUI",       32'h123450B7, 0, 0, 1'b0, 1'b0, -1);
    run_instr("AUIPC",     32'h00001097, 0, 0, 1'b0, 1'b0, -1);
    run_instr("JAL",       32'h008000EF, 0, 0, 1'b0, 1'b0, -1);

    // Abort an ADD where WB would be, and a store in its completing MEM cycle.
    run_instr("ADD abort", 32'h002081B3, 0, 0, 1'b0, 1'b0, 3);
    do_reset("abort wb", 1);
    run_instr("SW abort",  32'h0020A423, 0, 0, 1'b0, 1'b0, 3);
    do_reset("abort mem", 2);

    // Randomised legal instructions with random memory wait states.
    for (int n = 0; n < 200; n++) begin
      w = rand_legal();
      run_instr($sformatf("rnd%0d %h", n, w), w, $urandom_range(0, 2),
                $urandom_range(0, 2), 1'($urandom), 1'($urandom), -1);
    end

    // Illegal opcodes trap until reset.
    run_illegal("ILL 7F", 32'h0000007F, 10);
    for (int n = 0; n < 5; n++) begin
      w = $urandom;
      while (is_legal(w[6:0])) w = $urandom;
      run_illegal($sformatf("ILL rnd%0d %h", n, w), w, 4);
      run_instr($sformatf("post-trap%0d", n), rand_legal(), 0, 0, 1'b0, 1'b1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_ctrl.md
# riscv_multicycle_ctrl

Multi-cycle control FSM for the non-pipelined RISC-V core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback, and drives every datapath select: the ALU operand muxes (asel/bsel), the immediate generator, the ALU op, the branch comparator, the PC/writeback muxes and the IMEM/DMEM request handshakes. Supports RV32I base integer instructions, excluding FENCE and SYSTEM; illegal opcodes trap.

## Interface
Parameters:
- DATA_WIDTH, 32, width of inst.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- inst  in  DATA_WIDTH  instruction-register output; stable from DECODE until the next FETCH.
- br_eq  in  1  comparator rs1==rs2.
- br_lt  in  1  comparator rs1<rs2; signedness per brun.
- imem_ready  in  1  instruction word valid on this cycle.
- dmem_ready  in  1  data access completes this cycle.
- imem_req  out  1  fetch request.
- inst_we  out  1  load the instruction register.
- dmem_req  out  1  data access request.
- mem_rw  out  1  1 = store, 0 = load.
- pc_we  out  1  update PC.
- pc_sel  out  1  0 = PC+4, 1 = ALU result.
- asel  out  1  0 = rs1, 1 = PC.
- bsel  out  1  0 = rs2, 1 = imm.
- imm_sel  out  3  0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
- alu_sel  out  4  0 = ADD, 1 = SUB, 2 = SLL, 3 = SLT, 4 = SLTU, 5 = XOR, 6 = SRL, 7 = SRA, 8 = OR, 9 = AND, 10 = PASSB.
- brun  out  1  unsigned compare.
- regwen  out  1  register-file write enable.
- wbsel  out  2  0 = DMEM, 1 = ALU, 2 = PC+4.
- trap  out  1  illegal instruction; sticky.

## Operation
- States: BOOT, FETCH, DECODE, EXEC, MEM, WB, TRAP. The state register is the only storage. Outputs are combinational from the state and inst (Moore plus decode).
- BOOT: all outputs 0. Next state is FETCH.
- FETCH: imem_req=1. Hold while imem_ready=0. On imem_ready=1: inst_we=1 in the same cycle, then go to DECODE.
- DECODE: one cycle. Opcode inst[6:0] must be one of 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111 or 0010111. Any other opcode goes to TRAP.
- EXEC: one cycle. Loads and stores go to MEM; all other instructions go to WB.
- MEM: dmem_req=1, mem_rw=1 for stores. Hold while dmem_ready=0. On dmem_ready: a load goes to WB; a store asserts pc_we=1 with pc_sel=0 and goes to FETCH.
- WB: one cycle, then FETCH.
  - pc_we=1.
  - regwen=1 except for branches.
  - pc_sel=1 for JAL, for JALR, and for a taken branch.
- TRAP: trap=1 and all other outputs 0. Held until rst.
- Operand decode is driven in EXEC, MEM and WB so the ALU result stays stable:
  - R-type: bsel=0. alu_sel from funct3, with inst[30] selecting SUB/SRA.
  - I-ALU: bsel=1, imm I. inst[30] is honoured only for funct3=101 (SRAI).
  - Load: ADD, bsel=1, imm I, wbsel=0.
  - Store: ADD, bsel=1, imm S.
  - Branch: asel=1, bsel=1, ADD, imm B. brun=inst[13]. Taken condition by funct3: BEQ eq, BNE !eq, BLT lt, BGE !lt, BLTU lt, BGEU !lt.
  - JAL: asel=1, bsel=1, ADD, imm J, wbsel=2.
  - JALR: asel=0, bsel=1, ADD, imm I, wbsel=2.
  - LUI: bsel=1, PASSB, imm U.
  - AUIPC: asel=1, bsel=1, ADD, imm U.
  - wbsel=1 for all other register writes.
- In BOOT, FETCH, DECODE and TRAP, asel/bsel/imm_sel/alu_sel/brun/wbsel are 0.

## Timing
- Reset: state becomes BOOT immediately, and all outputs are 0 while rst=1. The first imem_req is asserted 1 cycle after rst deasserts.
- Latency with zero-wait memory:
  - ALU, branch and jump instructions take 4 cycles (FETCH, DECODE, EXEC, WB).
  - Stores take 4 cycles (FETCH, DECODE, EXEC, MEM).
  - Loads take 5 cycles.
  - Each memory wait cycle adds one cycle.
- Handshakes: a request is held high until its ready is sampled high. A ready seen outside FETCH or MEM is ignored.
- pc_we pulses for exactly one cycle per retired instruction. regwen pulses for at most one cycle.
- rst asserted mid-instruction aborts the instruction: no pc_we or regwen is issued after rst rises.

## Structure
- Shared package riscv_ctrl_pkg holds:
  - the state enum;
  - opcode constants;
  - alu_sel, imm_sel and wbsel encodings;
  - pc_sel, asel and bsel values.
- Sub-module riscv_ctrl_decode is purely combinational. It maps inst, br_eq and br_lt to select fields, is_load, is_store, is_branch, taken and illegal. The FSM top gates these by state.

## Test plan
- Reset and BOOT: hold rst for 3 cycles, release. All outputs are 0 during reset; imem_req=1 exactly 1 cycle after release.
- ADD x3,x1,x2 (0x002081B3) with imem_ready=1 immediately:
  - inst_we in FETCH;
  - in EXEC, alu_sel=0, asel=0, bsel=0;
  - in WB, regwen=1, wbsel=1, pc_we=1, pc_sel=0;
  - back in FETCH on cycle 5.
- LW x5,8(x1) (0x0080A283) with dmem_ready delayed 2 cycles:
  - dmem_req high for 3 cycles with mem_rw=0;
  - then WB with wbsel=0, regwen=1;
  - total 7 cycles.
- BNE with br_eq=0 (0x00209463): pc_sel=1 and regwen=0 in WB, brun=0. Repeat with br_eq=1: pc_sel=0.
- BLTU with br_lt=1 (0x0020E463): brun=1, pc_sel=1. Also JALR (0x000080E7): asel=0, bsel=1, wbsel=2, pc_sel=1.
- Illegal opcode 0x0000007F: TRAP entered after DECODE; trap=1 with imem_req=0 held for 10 cycles; rst then returns the FSM to BOOT.
